decode_stage: RTL

RV32I instruction-decode stage. It sits between the fetch stage and the register file / execute stage.
- Drives the register-file read addresses combinationally from the fetched instruction.
- Generates the immediate and control signals.
- Detects load-use hazards.
- Captures everything into the ID/EX pipeline register with a valid/ready handshake on both sides.

---
 rtl/decode_stage_if.sv | 58 +++++
 rtl/decode_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Signal bundle between fetch, register file, decode_stage and execute.
// ex_illegal is present only when ILLEGAL_DETECT_EN is defined.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;
  logic            flush;
  logic            ex_ready;
  logic [4:0]      rf_readReg1;
  logic [4:0]      rf_readReg2;
  logic [31:0]     rf_readData1;
  logic [31:0]     rf_readData2;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_rs1_data;
  logic [31:0]     ex_rs2_data;
  logic [31:0]     ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic            ex_funct7b5;
  logic            ex_regwrite;
  logic            ex_memread;
  logic            ex_memwrite;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_alusrc;
`ifdef ILLEGAL_DETECT_EN
  logic            ex_illegal;
`endif

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready, rf_readData1, rf_readData2,
    output if_ready, rf_readReg1, rf_readReg2,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    output ex_opcode, ex_funct3, ex_funct7b5,
    output ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_alusrc
`ifdef ILLEGAL_DETECT_EN
    , output ex_illegal
`endif
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready, rf_readData1, rf_readData2,
    input  if_ready, rf_readReg1, rf_readReg2,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
    input  ex_opcode, ex_funct3, ex_funct7b5,
    input  ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_alusrc
`ifdef ILLEGAL_DETECT_EN
    , input ex_illegal
`endif
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode and register-file addressing, load-use stall,
// and a valid/ready ID/EX register. Defining ILLEGAL_DETECT_EN adds the ex_illegal flag.
module decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic alusrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 6'b000000;

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s, rf_addr1_s, rf_addr2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_s;
  logic        uses_rs1_s, uses_rs2_s, hazard_s;
  ctrl_t       ctrl_dec_s, ctrl_s;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [31:0]     ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0]     ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [6:0]      ex_opcode_q, ex_opcode_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;

  assign instr_s  = bus.if_instr;
  assign opcode_s = instr_s[6:0];
  assign rd_s     = instr_s[11:7];
  assign funct3_s = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];

  // Per-opcode immediate format, control bits and operand usage
  always_comb begin
    imm_s      = 32'h0000_0000;
    ctrl_dec_s = CTRL_NONE;
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        ctrl_dec_s.regwrite = 1'b1;
        uses_rs2_s          = 1'b1;
      end
      OP_I: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        imm_s               = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OP_LOAD: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.memread  = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        imm_s               = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OP_STORE: begin
        ctrl_dec_s.memwrite = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        uses_rs2_s          = 1'b1;
        imm_s               = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
      end
      OP_BRANCH: begin
        ctrl_dec_s.branch = 1'b1;
        uses_rs2_s        = 1'b1;
        imm_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
      end
      OP_JAL: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.jump     = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        uses_rs1_s          = 1'b0;
        imm_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.jump     = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        imm_s               = {{20{instr_s[31]}}, instr_s[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_dec_s.regwrite = 1'b1;
        ctrl_dec_s.alusrc   = 1'b1;
        uses_rs1_s          = 1'b0;
        imm_s               = {instr_s[31:12], 12'h000};
      end
      default: begin
        ctrl_dec_s = CTRL_NONE;
      end
    endcase
    ctrl_dec_s.regwrite = ctrl_dec_s.regwrite & (rd_s != 5'd0);
  end

`ifdef ILLEGAL_DETECT_EN
  logic ex_illegal_q, ex_illegal_d, illegal_s;

  // Unknown opcodes and funct3 encodings undefined for loads, stores, branches and JALR
  always_comb begin
    illegal_s = 1'b0;
    case (opcode_s)
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: illegal_s = 1'b0;
      OP_LOAD:   illegal_s = (funct3_s == 3'b011) | (funct3_s[2:1] == 2'b11);
      OP_STORE:  illegal_s = funct3_s[2] | (funct3_s[1:0] == 2'b11);
      OP_BRANCH: illegal_s = (funct3_s[2:1] == 2'b01);
      OP_JALR:   illegal_s = (funct3_s != 3'b000);
      default:   illegal_s = 1'b1;
    endcase
  end
  assign ctrl_s = illegal_s ? CTRL_NONE : ctrl_dec_s;
`else
  assign ctrl_s = ctrl_dec_s;
`endif

  assign rf_addr1_s = uses_rs1_s ? rs1_s : 5'd0;
  assign rf_addr2_s = uses_rs2_s ? rs2_s : 5'd0;

  // Only a load still sitting in ID/EX can stall; its data is not ready for a dependent op
  assign hazard_s = ex_valid_q & ex_ctrl_q.memread & (ex_rd_q != 5'd0) &
                    ((uses_rs1_s & (rs1_s == ex_rd_q)) | (uses_rs2_s & (rs2_s == ex_rd_q)));

  // ID/EX next state: flush, then stall, then hazard bubble, then capture, else idle bubble
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_ctrl_d     = ex_ctrl_q;
`ifdef ILLEGAL_DETECT_EN
    ex_illegal_d  = ex_illegal_q;
`endif
    if (bus.flush || (bus.ex_ready && (hazard_s || !bus.if_valid))) begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = CTRL_NONE;
`ifdef ILLEGAL_DETECT_EN
      ex_illegal_d = 1'b0;
`endif
    end else if (bus.ex_ready) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = bus.if_pc;
      ex_rs1_data_d = bus.rf_readData1;
      ex_rs2_data_d = bus.rf_readData2;
      ex_imm_d      = imm_s;
      ex_rs1_d      = rf_addr1_s;
      ex_rs2_d      = rf_addr2_s;
      ex_rd_d       = rd_s;
      ex_opcode_d   = opcode_s;
      ex_funct3_d   = funct3_s;
      ex_funct7b5_d = instr_s[30];
      ex_ctrl_d     = ctrl_s;
`ifdef ILLEGAL_DETECT_EN
      ex_illegal_d  = illegal_s;
`endif
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= RESET_PC;
      ex_rs1_data_q <= 32'h0000_0000;
      ex_rs2_data_q <= 32'h0000_0000;
      ex_imm_q      <= 32'h0000_0000;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_rd_q       <= 5'd0;
      ex_opcode_q   <= 7'd0;
      ex_funct3_q   <= 3'd0;
      ex_funct7b5_q <= 1'b0;
      ex_ctrl_q     <= CTRL_NONE;
`ifdef ILLEGAL_DETECT_EN
      ex_illegal_q  <= 1'b0;
`endif
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_ctrl_q     <= ex_ctrl_d;
`ifdef ILLEGAL_DETECT_EN
      ex_illegal_q  <= ex_illegal_d;
`endif
    end
  end

  assign bus.if_ready    = bus.flush | (bus.ex_ready & ~hazard_s);
  assign bus.rf_readReg1 = rf_addr1_s;
  assign bus.rf_readReg2 = rf_addr2_s;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rs1      = ex_rs1_q;
  assign bus.ex_rs2      = ex_rs2_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_opcode   = ex_opcode_q;
  assign bus.ex_funct3   = ex_funct3_q;
  assign bus.ex_funct7b5 = ex_funct7b5_q;
  assign bus.ex_regwrite = ex_ctrl_q.regwrite;
  assign bus.ex_memread  = ex_ctrl_q.memread;
  assign bus.ex_memwrite = ex_ctrl_q.memwrite;
  assign bus.ex_branch   = ex_ctrl_q.branch;
  assign bus.ex_jump     = ex_ctrl_q.jump;
  assign bus.ex_alusrc   = ex_ctrl_q.alusrc;
`ifdef ILLEGAL_DETECT_EN
  assign bus.ex_illegal  = ex_illegal_q;
`endif
endmodule
